// File: rtl/ysyx_22041412_axi_arbiter.sv
// Shares one downstream AXI-bridge port between the Icache (read refills) and the Dcache
// (refills and write-backs). One whole burst is granted at a time, round-robin between caches.
module ysyx_22041412_axi_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_r_valid_i,
    input  logic [ADDR_WIDTH-1:0] i_r_addr_i,
    input  logic [7:0]            i_r_len_i,
    output logic                  i_r_ready_o,
    output logic                  i_r_last_o,
    output logic [DATA_WIDTH-1:0] i_r_data_o,

    input  logic                  d_r_valid_i,
    input  logic [ADDR_WIDTH-1:0] d_r_addr_i,
    input  logic [7:0]            d_r_len_i,
    output logic                  d_r_ready_o,
    output logic                  d_r_last_o,
    output logic [DATA_WIDTH-1:0] d_r_data_o,

    input  logic                  d_w_valid_i,
    input  logic [ADDR_WIDTH-1:0] d_w_addr_i,
    input  logic [7:0]            d_w_len_i,
    input  logic [2:0]            d_w_size_i,
    input  logic [DATA_WIDTH-1:0] d_w_data_i,
    output logic                  d_w_ready_o,
    output logic                  d_w_last_o,

    output logic                  m_r_valid_o,
    output logic [ADDR_WIDTH-1:0] m_r_addr_o,
    output logic [7:0]            m_r_len_o,
    input  logic                  m_r_ready_i,
    input  logic                  m_r_last_i,
    input  logic [DATA_WIDTH-1:0] m_r_data_i,

    output logic                  m_w_valid_o,
    output logic [ADDR_WIDTH-1:0] m_w_addr_o,
    output logic [7:0]            m_w_len_o,
    output logic [2:0]            m_w_size_o,
    output logic [DATA_WIDTH-1:0] m_w_data_o,
    input  logic                  m_w_ready_i,
    input  logic                  m_w_last_i,

    output logic [1:0]            grant_o
);

    // Handshake: a requester holds valid/addr/len for its whole burst; each cycle with
    // ready=1 is one beat, and the beat with ready=1 and last=1 ends the burst.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        I_RD = 2'b01,
        D_RD = 2'b10,
        D_WR = 2'b11
    } state_e;

    state_e state_q, state_d;
    logic   prefer_i_q, prefer_i_d;
    logic   d_cand;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            prefer_i_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prefer_i_q <= prefer_i_d;
        end
    end

    // Next-state: arbitrate only in IDLE; otherwise wait for the final beat.
    always_comb begin
        state_d    = state_q;
        prefer_i_d = prefer_i_q;
        d_cand     = d_w_valid_i | d_r_valid_i;
        case (state_q)
            IDLE: begin
                if (i_r_valid_i && (!d_cand || prefer_i_q)) begin
                    state_d = I_RD;
                end else if (d_w_valid_i) begin
                    state_d = D_WR;
                end else if (d_r_valid_i) begin
                    state_d = D_RD;
                end
            end
            I_RD: begin
                if (m_r_ready_i && m_r_last_i) begin
                    state_d    = IDLE;
                    prefer_i_d = 1'b0;
                end
            end
            D_RD: begin
                if (m_r_ready_i && m_r_last_i) begin
                    state_d    = IDLE;
                    prefer_i_d = 1'b1;
                end
            end
            D_WR: begin
                if (m_w_ready_i && m_w_last_i) begin
                    state_d    = IDLE;
                    prefer_i_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Routing is purely a function of the registered grant, so reset clears every output at once.
    always_comb begin
        i_r_ready_o = 1'b0;
        i_r_last_o  = 1'b0;
        i_r_data_o  = '0;
        d_r_ready_o = 1'b0;
        d_r_last_o  = 1'b0;
        d_r_data_o  = '0;
        d_w_ready_o = 1'b0;
        d_w_last_o  = 1'b0;
        m_r_valid_o = 1'b0;
        m_r_addr_o  = '0;
        m_r_len_o   = '0;
        m_w_valid_o = 1'b0;
        m_w_addr_o  = '0;
        m_w_len_o   = '0;
        m_w_size_o  = '0;
        m_w_data_o  = '0;
        case (state_q)
            I_RD: begin
                m_r_valid_o = i_r_valid_i;
                m_r_addr_o  = i_r_addr_i;
                m_r_len_o   = i_r_len_i;
                i_r_ready_o = m_r_ready_i;
                i_r_last_o  = m_r_last_i;
                i_r_data_o  = m_r_data_i;
            end
            D_RD: begin
                m_r_valid_o = d_r_valid_i;
                m_r_addr_o  = d_r_addr_i;
                m_r_len_o   = d_r_len_i;
                d_r_ready_o = m_r_ready_i;
                d_r_last_o  = m_r_last_i;
                d_r_data_o  = m_r_data_i;
            end
            D_WR: begin
                m_w_valid_o = d_w_valid_i;
                m_w_addr_o  = d_w_addr_i;
                m_w_len_o   = d_w_len_i;
                m_w_size_o  = d_w_size_i;
                m_w_data_o  = d_w_data_i;
                d_w_ready_o = m_w_ready_i;
                d_w_last_o  = m_w_last_i;
            end
            default: ;
        endcase
    end

    assign grant_o = state_q;

endmodule

// File: tb/tb_ysyx_22041412_axi_arbiter.sv
// Randomised bench for the cache-to-bridge burst arbiter: a transaction-level model predicts
// every grant (who, when, which address/len); a negedge monitor checks grants and beat routing.
module tb_ysyx_22041412_axi_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int EW = 74;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: 0 = Icache read, 1 = Dcache read, 2 = Dcache write.
    logic          req_v    [3];
    logic [AW-1:0] req_addr [3];
    logic [7:0]    req_len  [3];
    logic [2:0]    w_size;
    logic [DW-1:0] w_data;
    logic          br_ready, br_last, bw_ready, bw_last;
    logic [DW-1:0] br_data;

    logic          i_r_ready_o, i_r_last_o, d_r_ready_o, d_r_last_o, d_w_ready_o, d_w_last_o;
    logic [DW-1:0] i_r_data_o, d_r_data_o, m_w_data_o;
    logic          m_r_valid_o, m_w_valid_o;
    logic [AW-1:0] m_r_addr_o, m_w_addr_o;
    logic [7:0]    m_r_len_o, m_w_len_o;
    logic [2:0]    m_w_size_o;
    logic [1:0]    grant_o;

    ysyx_22041412_axi_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_r_valid_i(req_v[0]), .i_r_addr_i(req_addr[0]), .i_r_len_i(req_len[0]),
        .i_r_ready_o(i_r_ready_o), .i_r_last_o(i_r_last_o), .i_r_data_o(i_r_data_o),
        .d_r_valid_i(req_v[1]), .d_r_addr_i(req_addr[1]), .d_r_len_i(req_len[1]),
        .d_r_ready_o(d_r_ready_o), .d_r_last_o(d_r_last_o), .d_r_data_o(d_r_data_o),
        .d_w_valid_i(req_v[2]), .d_w_addr_i(req_addr[2]), .d_w_len_i(req_len[2]),
        .d_w_size_i(w_size), .d_w_data_i(w_data),
        .d_w_ready_o(d_w_ready_o), .d_w_last_o(d_w_last_o),
        .m_r_valid_o(m_r_valid_o), .m_r_addr_o(m_r_addr_o), .m_r_len_o(m_r_len_o),
        .m_r_ready_i(br_ready), .m_r_last_i(br_last), .m_r_data_i(br_data),
        .m_w_valid_o(m_w_valid_o), .m_w_addr_o(m_w_addr_o), .m_w_len_o(m_w_len_o),
        .m_w_size_o(m_w_size_o), .m_w_data_o(m_w_data_o),
        .m_w_ready_i(bw_ready), .m_w_last_i(bw_last),
        .grant_o(grant_o)
    );

    // Expected grant record: {grant cycle[31:0], grant code[1:0], addr[31:0], len[7:0]}.
    logic [EW-1:0] exp_q[$];
    int checks = 0, errors = 0;
    int pushes = 0, pops = 0, dones = 0, aborted = 0;

    // Reference-model state: who owns the bridge, beats served, fairness flag.
    int            owner = -1, done_owner = -1, beat = 0;
    logic          prefer = 1'b0;
    logic          fv     [3];
    logic [AW-1:0] f_addr [3];
    logic [7:0]    f_len  [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] gcode(input int r);
        return (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b11;
    endfunction

    // One cycle of requesters, bridge and model; inputs change #1 after the edge.
    task automatic step(input bit allow_new, input bit stray);
        int d_cand, win;
        @(posedge clk);
        #1;
        if (done_owner >= 0) begin
            req_v[done_owner] = 1'b0;
            done_owner = -1;
        end
        br_ready = 1'b0; br_last = 1'b0; bw_ready = 1'b0; bw_last = 1'b0;
        br_data  = {$urandom, $urandom};
        w_data   = {$urandom, $urandom};
        w_size   = 3'($urandom_range(0, 3));
        for (int i = 0; i < 3; i++) begin
            if (fv[i]) begin
                req_v[i] = 1'b1; req_addr[i] = f_addr[i]; req_len[i] = f_len[i]; fv[i] = 1'b0;
            end else if (allow_new && !req_v[i] && $urandom_range(0, 2) == 0) begin
                req_v[i]    = 1'b1;
                req_addr[i] = $urandom & 32'hFFFF_FFF8;
                req_len[i]  = 8'($urandom_range(0, 3));
            end
        end
        if (owner < 0) begin
            d_cand = req_v[2] ? 2 : (req_v[1] ? 1 : -1);
            if (req_v[0] && (d_cand < 0 || prefer)) win = 0;
            else win = d_cand;
            if (win >= 0) begin
                exp_q.push_back({32'(cyc + 1), gcode(win), req_addr[win], req_len[win]});
                pushes++;
                owner = win;
                beat  = 0;
            end else if (stray && $urandom_range(0, 3) == 0) begin
                br_ready = 1'b1; br_last = 1'($urandom_range(0, 1));
                bw_ready = 1'($urandom_range(0, 1)); bw_last = 1'b1;
            end
        end else if ($urandom_range(0, 3) != 0) begin
            if (owner == 2) bw_ready = 1'b1;
            else br_ready = 1'b1;
            if (beat == int'(req_len[owner])) begin
                if (owner == 2) bw_last = 1'b1;
                else br_last = 1'b1;
                prefer     = (owner != 0);
                done_owner = owner;
                owner      = -1;
            end else begin
                beat++;
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (k < 400 && (owner >= 0 || done_owner >= 0 || req_v[0] || req_v[1] || req_v[2])) begin
            step(1'b0, 1'b0);
            k++;
        end
        if (k >= 400) chk("drain_timeout", 64'(k), 64'd0);
    endtask

    // Monitor: pops the predicted grant when one appears, then checks routing every cycle.
    logic [1:0]    mon_g = 2'b00;
    bit            expect_idle = 1'b0;
    logic [EW-1:0] e;
    initial begin
        logic gi, gd, gw;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_g = 2'b00;
                expect_idle = 1'b0;
            end else begin
                if (expect_idle) begin
                    chk("bubble_idle", 64'(grant_o), 64'd0);
                    expect_idle = 1'b0;
                end
                if (mon_g == 2'b00 && grant_o != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", 64'(grant_o), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        pops++;
                        chk("grant_code", 64'(grant_o), 64'(e[41:40]));
                        chk("grant_cycle", 64'(cyc), 64'(e[73:42]));
                        chk("grant_addr", 64'((grant_o == 2'b11) ? m_w_addr_o : m_r_addr_o), 64'(e[39:8]));
                        chk("grant_len", 64'((grant_o == 2'b11) ? m_w_len_o : m_r_len_o), 64'(e[7:0]));
                        mon_g = e[41:40];
                    end
                end
                if (mon_g == 2'b00) begin
                    chk("idle_quiet", 64'({i_r_ready_o, i_r_last_o, d_r_ready_o, d_r_last_o,
                        d_w_ready_o, d_w_last_o, m_r_valid_o, m_w_valid_o}), 64'd0);
                end else begin
                    gi = (mon_g == 2'b01);
                    gd = (mon_g == 2'b10);
                    gw = (mon_g == 2'b11);
                    chk("grant_hold", 64'(grant_o), 64'(mon_g));
                    chk("ret_strobes",
                        64'({i_r_ready_o, i_r_last_o, d_r_ready_o, d_r_last_o, d_w_ready_o, d_w_last_o}),
                        64'({gi & br_ready, gi & br_last, gd & br_ready, gd & br_last,
                             gw & bw_ready, gw & bw_last}));
                    chk("i_r_data", i_r_data_o, gi ? br_data : 64'd0);
                    chk("d_r_data", d_r_data_o, gd ? br_data : 64'd0);
                    chk("m_valid", 64'({m_r_valid_o, m_w_valid_o}),
                        64'({gi ? req_v[0] : (gd ? req_v[1] : 1'b0), gw ? req_v[2] : 1'b0}));
                    chk("m_r_req", 64'({m_r_addr_o, m_r_len_o}),
                        gi ? 64'({req_addr[0], req_len[0]}) : (gd ? 64'({req_addr[1], req_len[1]}) : 64'd0));
                    chk("m_w_req", 64'({m_w_addr_o, m_w_len_o, m_w_size_o}),
                        gw ? 64'({req_addr[2], req_len[2], w_size}) : 64'd0);
                    chk("m_w_data", m_w_data_o, gw ? w_data : 64'd0);
                    if ((gw && bw_ready && bw_last) || (!gw && br_ready && br_last)) begin
                        mon_g = 2'b00;
                        expect_idle = 1'b1;
                        dones++;
                    end
                end
            end
        end
    end

    initial begin
        int k;
        for (int i = 0; i < 3; i++) begin
            req_v[i] = 1'b0; req_addr[i] = '0; req_len[i] = '0;
            fv[i] = 1'b0; f_addr[i] = '0; f_len[i] = '0;
        end
        w_size = '0; w_data = '0; br_ready = 1'b0; br_last = 1'b0; bw_ready = 1'b0; bw_last = 1'b0;
        br_data = '0;

        #2;
        chk("reset_grant", 64'(grant_o), 64'd0);
        chk("reset_m_valid", 64'({m_r_valid_o, m_w_valid_o}), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single Icache refill, 4 beats.
        fv[0] = 1'b1; f_addr[0] = 32'h8000_0000; f_len[0] = 8'd3;
        drain();
        // Icache and Dcache read together: D first.
        fv[0] = 1'b1; f_addr[0] = 32'h8000_0040; f_len[0] = 8'd1;
        fv[1] = 1'b1; f_addr[1] = 32'h8000_0080; f_len[1] = 8'd2;
        drain();
        // Dcache write and read together: write first.
        fv[1] = 1'b1; f_addr[1] = 32'h8000_0200; f_len[1] = 8'd0;
        fv[2] = 1'b1; f_addr[2] = 32'h8000_0100; f_len[2] = 8'd1;
        drain();
        // Randomised contention with stray bridge beats while idle.
        repeat (1500) step(1'b1, 1'b1);
        drain();

        // Reset in the middle of a 4-beat Dcache read.
        fv[1] = 1'b1; f_addr[1] = 32'h8000_0300; f_len[1] = 8'd3;
        k = 0;
        do begin
            step(1'b0, 1'b0);
            k++;
        end while (!(owner == 1 && beat == 2) && k < 200);
        if (k >= 200) chk("midreset_wait_timeout", 64'(k), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_grant", 64'(grant_o), 64'd0);
        chk("midreset_outputs", 64'({m_r_valid_o, d_r_ready_o, d_r_last_o}), 64'd0);
        for (int i = 0; i < 3; i++) req_v[i] = 1'b0;
        br_ready = 1'b0; br_last = 1'b0; bw_ready = 1'b0; bw_last = 1'b0;
        owner = -1; done_owner = -1; beat = 0; prefer = 1'b0;
        aborted++;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        fv[1] = 1'b1; f_addr[1] = 32'h8000_0300; f_len[1] = 8'd3;
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("grants_seen", 64'(pops), 64'(pushes));
        chk("bursts_done", 64'(dones), 64'(pushes - aborted));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
